// File: rtl/alu_arbiter.sv
// Round-robin scheduler sharing one alu_top between two requesters. It holds the ALU
// inputs for a per-opcode latency and returns the sampled results on a tagged response.
//   state | meaning
//   IDLE  | arbitrating, readies may assert
//   EXEC  | ALU inputs driven, latency counting down
//   DONE  | response valid, waiting for rsp_ready
module alu_arbiter #(
    parameter int ALU_LAT = 2,
    parameter int MUL_LAT = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_opcode,
    input  logic [15:0] req0_opx,
    input  logic [15:0] req0_opy,
    input  logic        req0_cin,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_opcode,
    input  logic [15:0] req1_opx,
    input  logic [15:0] req1_opy,
    input  logic        req1_cin,
    output logic [3:0]  alu_opcode,
    output logic [15:0] alu_opx,
    output logic [15:0] alu_opy,
    output logic        alu_cin,
    input  logic [15:0] alu_ar,
    input  logic [31:0] alu_mult,
    input  logic [3:0]  alu_sta,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_ar,
    output logic [31:0] rsp_mult,
    output logic [3:0]  rsp_sta,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [4:0] ALU_LOAD = 5'(ALU_LAT - 1);
    localparam logic [4:0] MUL_LOAD = 5'(MUL_LAT - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_last_grant;
    logic        r_id;
    logic [3:0]  r_opcode;
    logic [15:0] r_opx;
    logic [15:0] r_opy;
    logic        r_cin;
    logic [4:0]  r_cnt;
    logic [15:0] r_rsp_ar;
    logic [31:0] r_rsp_mult;
    logic [3:0]  r_rsp_sta;
    logic        r_rsp_err;

    logic        w_grant_id;
    logic        w_accept;
    logic [3:0]  w_sel_opcode;
    logic [15:0] w_sel_opx;
    logic [15:0] w_sel_opy;
    logic        w_sel_cin;
    logic        w_illegal;
    logic        w_is_mul;
    logic        w_exec_last;

    // With both valid, the requester that did not win last time gets the grant.
    always_comb begin
        w_grant_id   = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
        req0_ready   = (r_state == IDLE) && req0_valid && !w_grant_id;
        req1_ready   = (r_state == IDLE) && req1_valid && w_grant_id;
        w_accept     = req0_ready || req1_ready;
        w_sel_opcode = w_grant_id ? req1_opcode : req0_opcode;
        w_sel_opx    = w_grant_id ? req1_opx : req0_opx;
        w_sel_opy    = w_grant_id ? req1_opy : req0_opy;
        w_sel_cin    = w_grant_id ? req1_cin : req0_cin;
        w_illegal    = (w_sel_opcode == 4'hF);
        w_is_mul     = (w_sel_opcode >= 4'hB);
        w_exec_last  = (r_state == EXEC) && (r_cnt == 5'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_illegal ? DONE : EXEC;
            EXEC:    if (r_cnt == 5'd0) w_next = DONE;
            DONE:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operands are only captured for legal opcodes so the ALU never sees an illegal command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_opcode     <= 4'h0;
            r_opx        <= 16'h0;
            r_opy        <= 16'h0;
            r_cin        <= 1'b0;
            r_cnt        <= 5'd0;
            r_rsp_ar     <= 16'h0;
            r_rsp_mult   <= 32'h0;
            r_rsp_sta    <= 4'h0;
            r_rsp_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_id         <= w_grant_id;
                r_last_grant <= w_grant_id;
                if (w_illegal) begin
                    r_rsp_ar   <= 16'h0;
                    r_rsp_mult <= 32'h0;
                    r_rsp_sta  <= 4'h0;
                    r_rsp_err  <= 1'b1;
                end else begin
                    r_opcode <= w_sel_opcode;
                    r_opx    <= w_sel_opx;
                    r_opy    <= w_sel_opy;
                    r_cin    <= w_sel_cin;
                    r_cnt    <= w_is_mul ? MUL_LOAD : ALU_LOAD;
                end
            end
            if (w_exec_last) begin
                r_rsp_ar   <= alu_ar;
                r_rsp_mult <= alu_mult;
                r_rsp_sta  <= alu_sta;
                r_rsp_err  <= 1'b0;
            end else if (r_state == EXEC) begin
                r_cnt <= r_cnt - 5'd1;
            end
        end
    end

    always_comb begin
        alu_opcode = (r_state == EXEC) ? r_opcode : 4'h0;
        alu_opx    = r_opx;
        alu_opy    = r_opy;
        alu_cin    = r_cin;
        rsp_valid  = (r_state == DONE);
        rsp_id     = r_id;
        rsp_ar     = r_rsp_ar;
        rsp_mult   = r_rsp_mult;
        rsp_sta    = r_rsp_sta;
        rsp_err    = r_rsp_err;
        busy       = (r_state != IDLE);
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expected responses are queued at accept and
// compared when rsp_valid rises, together with latency and ALU drive duration.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_cin;
    logic [3:0]  req0_opcode;
    logic [15:0] req0_opx, req0_opy;
    logic        req1_valid, req1_ready, req1_cin;
    logic [3:0]  req1_opcode;
    logic [15:0] req1_opx, req1_opy;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_opx, alu_opy;
    logic        alu_cin;
    logic [15:0] alu_ar;
    logic [31:0] alu_mult;
    logic [3:0]  alu_sta;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [15:0] rsp_ar;
    logic [31:0] rsp_mult;
    logic [3:0]  rsp_sta;

    alu_arbiter #(.ALU_LAT(2), .MUL_LAT(18)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_opx(req0_opx), .req0_opy(req0_opy), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_opx(req1_opx), .req1_opy(req1_opy), .req1_cin(req1_cin),
        .alu_opcode(alu_opcode), .alu_opx(alu_opx), .alu_opy(alu_opy), .alu_cin(alu_cin),
        .alu_ar(alu_ar), .alu_mult(alu_mult), .alu_sta(alu_sta),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_ar(rsp_ar), .rsp_mult(rsp_mult), .rsp_sta(rsp_sta), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [15:0] ar;
        logic [31:0] mult;
        logic [3:0]  sta;
        logic        err;
        logic [3:0]  op;
        int          lat;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Expected result model: latency class from opcode, results from the ALU stub.
    task automatic push_exp(input logic id, input logic [3:0] op);
        exp_t e;
        e.id   = id;
        e.op   = op;
        e.err  = (op == 4'hF);
        e.lat  = (op == 4'hF) ? 0 : (op >= 4'hB) ? 18 : 2;
        e.ar   = e.err ? 16'h0 : alu_ar;
        e.mult = e.err ? 32'h0 : alu_mult;
        e.sta  = e.err ? 4'h0 : alu_sta;
        e.cyc  = cyc + e.lat;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        logic prev_rsp;
        int   op_cycles;
        logic [3:0] last_op;
        exp_t e;
        prev_rsp  = 1'b0;
        op_cycles = 0;
        last_op   = 4'h0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                prev_rsp  = 1'b0;
                op_cycles = 0;
                last_op   = 4'h0;
            end else begin
                if (alu_opcode != 4'h0) begin
                    op_cycles++;
                    last_op = alu_opcode;
                end
                if (req0_ready && req1_ready) check("ready_exclusive", 1, 0);
                if (busy && (req0_ready || req1_ready)) check("ready_while_busy", 1, 0);
                if (rsp_valid && !prev_rsp) begin
                    if (exp_q.size() == 0) begin
                        check("stale_rsp", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_id", rsp_id, e.id);
                        check("rsp_ar", rsp_ar, e.ar);
                        check("rsp_mult", rsp_mult, e.mult);
                        check("rsp_sta", rsp_sta, e.sta);
                        check("rsp_err", rsp_err, e.err);
                        check("rsp_cycle", cyc, e.cyc);
                        check("alu_drive_cycles", op_cycles, e.lat);
                        if (e.lat > 0) check("alu_opcode", last_op, e.op);
                    end
                    op_cycles = 0;
                end
                prev_rsp = rsp_valid;
            end
        end
    end

    task automatic issue(input logic id, input logic [3:0] op, input logic [15:0] x,
                         input logic [15:0] y, input logic c);
        bit done = 0;
        if (id) begin
            req1_valid = 1; req1_opcode = op; req1_opx = x; req1_opy = y; req1_cin = c;
        end else begin
            req0_valid = 1; req0_opcode = op; req0_opx = x; req0_opy = y; req0_cin = c;
        end
        for (int b = 0; b < 100 && !done; b++) begin
            #1;
            if (id ? req1_ready : req0_ready) begin
                @(posedge clk);
                #1;
                push_exp(id, op);
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) check("issue_timeout", 0, 1);
        @(negedge clk);
        if (id) req1_valid = 0;
        else    req0_valid = 0;
    endtask

    task automatic wait_idle(input string tag);
        bit done = 0;
        for (int b = 0; b < 200 && !done; b++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) done = 1;
        end
        if (!done) check(tag, 0, 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic gid;
        bit   got;
        rst = 0;
        req0_valid = 0; req0_opcode = 0; req0_opx = 0; req0_opy = 0; req0_cin = 0;
        req1_valid = 0; req1_opcode = 0; req1_opx = 0; req1_opy = 0; req1_cin = 0;
        rsp_ready = 1;
        alu_ar = 16'h1111; alu_mult = 32'h11112222; alu_sta = 4'h1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_alu_opcode", alu_opcode, 0);
        check("rst_alu_opx", alu_opx, 0);
        check("rst_rsp_fields", {rsp_id, rsp_ar, rsp_mult, rsp_sta, rsp_err}, 0);

        // Fairness: both requesters valid straight out of reset.
        rst = 1;
        req0_opcode = 4'h1; req0_opx = 16'h0001; req0_valid = 1;
        req1_opcode = 4'h1; req1_opx = 16'h0002; req1_valid = 1;
        for (int k = 0; k < 4; k++) begin
            got = 0;
            for (int b = 0; b < 50 && !got; b++) begin
                #1;
                if (req0_ready || req1_ready) got = 1;
                else @(negedge clk);
            end
            if (!got) begin
                check("fair_timeout", 0, 1);
            end else begin
                gid = req1_ready;
                check("grant_order", gid, k % 2);
                @(posedge clk);
                #1;
                push_exp(gid, 4'h1);
                @(negedge clk);
            end
        end
        req0_valid = 0; req1_valid = 0;
        wait_idle("fair_drain_timeout");

        // Single ALU op.
        alu_ar = 16'h1234; alu_sta = 4'h5; alu_mult = 32'h0000_0042;
        issue(0, 4'h1, 16'h00FF, 16'h0F0F, 0);
        wait_idle("alu_op_timeout");

        // Multiply.
        alu_mult = 32'hDEADBEEF; alu_ar = 16'h0BAD; alu_sta = 4'hA;
        issue(1, 4'hB, 16'd10259, 16'hD4C9, 0);
        check("mul_alu_opx", alu_opx, 16'd10259);
        check("mul_alu_opy", alu_opy, 16'hD4C9);
        wait_idle("mul_timeout");

        // Illegal opcode: ALU results must be ignored.
        alu_ar = 16'hFFFF; alu_mult = 32'hFFFF_FFFF; alu_sta = 4'hF;
        issue(0, 4'hF, 16'h1111, 16'h2222, 1);
        wait_idle("illegal_timeout");

        // Backpressure with req1 waiting.
        alu_ar = 16'h00A5; alu_mult = 32'h0000_5A5A; alu_sta = 4'h3;
        rsp_ready = 0;
        issue(0, 4'h2, 16'h0003, 16'h0004, 0);
        got = 0;
        for (int b = 0; b < 20 && !got; b++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
        end
        if (!got) check("bp_rsp_timeout", 0, 1);
        alu_ar = 16'h7777;
        req1_opcode = 4'h3; req1_opx = 16'h0055; req1_opy = 16'h00AA; req1_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_ar", rsp_ar, 16'h00A5);
            check("bp_rsp_id", rsp_id, 0);
            check("bp_req1_ready", req1_ready, 0);
            check("bp_busy", busy, 1);
        end
        rsp_ready = 1;
        @(posedge clk);
        #1;
        check("bp_release_busy", busy, 0);
        check("bp_release_req1_ready", req1_ready, 1);
        @(posedge clk);
        #1;
        push_exp(1, 4'h3);
        check("bp_accept_busy", busy, 1);
        @(negedge clk);
        req1_valid = 0;
        wait_idle("bp_drain_timeout");

        // Reset in cycle 5 of a multiply EXEC.
        issue(0, 4'hB, 16'h0100, 16'h0200, 0);
        repeat (4) @(posedge clk);
        #2;
        rst = 0;
        #1;
        check("mid_rst_alu_opcode", alu_opcode, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1;
        alu_ar = 16'hABCD; alu_mult = 32'h0000_1357; alu_sta = 4'h6;
        issue(0, 4'h1, 16'h0010, 16'h0020, 1);
        wait_idle("post_rst_timeout");

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
